cnt_step_gen: RTL



---
 rtl/cnt_step_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cnt_step_gen.sv
// cnt_step_gen
//   Drive side of an inc/dec counter interface. It accepts a target count over
//   a valid/ready handshake. It then issues single-cycle inc or dec pulses,
//   optionally spaced by GAP idle cycles, until an internal shadow count equals
//   the target. A downstream inc/dec counter on the same clock and reset
//   therefore tracks the shadow exactly.
//
// Ports
//   clk      in   system clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   tgt_vld  in   target valid
//   tgt      in   [WIDTH-1:0] target count
//   tgt_rdy  out  target ready, high only in IDLE
//   abort    in   stop stepping in STEP/GAP; shadow keeps its value
//   inc      out  increment pulse
//   dec      out  decrement pulse
//   busy     out  high in STEP or GAP
//   done     out  one-cycle pulse when the target is reached
//   shadow   out  [WIDTH-1:0] expected downstream counter value
module cnt_step_gen #(
  parameter int WIDTH    = 8,
  parameter int GAP      = 0,
  parameter bit SHORTEST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_vld,
  input  logic [WIDTH-1:0] tgt,
  output logic             tgt_rdy,
  input  logic             abort,
  output logic             inc,
  output logic             dec,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Half of the modulus: a forward distance up to and including this goes up.
  localparam logic [WIDTH-1:0] HALF   = {1'b1, {(WIDTH-1){1'b0}}};
  // The gap counter counts down to zero, so it loads GAP-1 for GAP idle cycles.
  localparam logic [7:0]       GAP_LD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             up_q, up_d;
  logic [7:0]       gap_q, gap_d;

  logic [WIDTH-1:0] fwd_dist;
  logic [WIDTH-1:0] shadow_step;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    tgt_d    = tgt_q;
    up_d     = up_q;
    gap_d    = gap_q;

    // Forward (upward) distance from shadow to the offered target, mod 2^WIDTH.
    fwd_dist    = tgt - shadow_q;
    // Shadow value after the pulse being issued this cycle.
    shadow_step = up_q ? (shadow_q + WIDTH'(1)) : (shadow_q - WIDTH'(1));

    unique case (state_q)
      S_IDLE: begin
        if (tgt_vld) begin
          tgt_d = tgt;
          if (SHORTEST) begin
            up_d = (fwd_dist <= HALF);
          end else begin
            up_d = (tgt > shadow_q);
          end
          state_d = (tgt == shadow_q) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        // The pulse is already on the wire this cycle, so the shadow follows
        // it even when the operation is aborted at this edge.
        shadow_d = shadow_step;
        if (abort) begin
          state_d = S_IDLE;
        end else if (shadow_step == tgt_q) begin
          state_d = S_DONE;
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LD;
        end else begin
          state_d = S_STEP;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q == 8'd0) begin
          state_d = S_STEP;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      tgt_q    <= '0;
      up_q     <= 1'b0;
      gap_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      tgt_q    <= tgt_d;
      up_q     <= up_d;
      gap_q    <= gap_d;
    end
  end

  // Moore outputs: decoded only from registered state so they fall
  // immediately when rst_n is asserted.
  assign tgt_rdy = (state_q == S_IDLE);
  assign inc     = (state_q == S_STEP) &&  up_q;
  assign dec     = (state_q == S_STEP) && !up_q;
  assign busy    = (state_q == S_STEP) || (state_q == S_GAP);
  assign done    = (state_q == S_DONE);
  assign shadow  = shadow_q;

`ifdef ASSERTS_SV
  a_inc_dec_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && dec));
  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);
  a_shadow_known: assert property (@(posedge clk)
    rst_n |-> !$isunknown(shadow));
  a_step_moves: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_STEP) |=>
      ((shadow == $past(shadow) + WIDTH'(1)) || (shadow == $past(shadow) - WIDTH'(1))));
`endif

endmodule
